// File: rtl/phys_free_list_if.sv
// Dispatch/retire/flush bundle of the physical-register free list.
// The slave side is the free list; the master side is the pipeline driving it.
interface phys_free_list_if #(
    parameter int N_WAY    = 2,
    parameter int N_ROB    = 32,
    parameter int TAG_BITS = 6
) ();
    logic [N_WAY-1:0]                 alloc_en;
    logic [N_WAY-1:0]                 retire_valid;
    logic [N_WAY-1:0][TAG_BITS-1:0]   retire_told;
    logic                             branch_haz;
    logic [N_ROB-1:0][TAG_BITS-1:0]   free_list_haz;
    logic [N_WAY-1:0][TAG_BITS-1:0]   free_tag;
    logic [N_WAY-1:0]                 free_valid;
    logic [$clog2(N_WAY):0]           num_free;
    logic [TAG_BITS:0]                free_count;
    logic                             double_free;

    modport slave (
        input  alloc_en, retire_valid, retire_told, branch_haz, free_list_haz,
        output free_tag, free_valid, num_free, free_count, double_free
    );

    modport master (
        output alloc_en, retire_valid, retire_told, branch_haz, free_list_haz,
        input  free_tag, free_valid, num_free, free_count, double_free
    );
endinterface

// File: rtl/phys_free_list.sv
// Bitmap free list of physical register tags: offers the lowest N_WAY free tags,
// reclaims tags on retirement and branch flush, and flags double frees.
module phys_free_list #(
    parameter int N_WAY       = 2,
    parameter int N_ROB       = 32,
    parameter int N_PHYS_REG  = 64,
    parameter int N_ARCH_REG  = 32,
    parameter int TAG_BITS    = 6,
    parameter int ZERO_REG_PR = 0
) (
    input  logic                clock,
    input  logic                reset,
    phys_free_list_if.slave     bus
);
    localparam int NF_BITS = $clog2(N_WAY) + 1;
    localparam logic [N_PHYS_REG-1:0] RESET_BITS = {N_PHYS_REG{1'b1}} << N_ARCH_REG;
    localparam logic [TAG_BITS-1:0]   ZERO_TAG   = TAG_BITS'(ZERO_REG_PR);

    logic [N_PHYS_REG-1:0]            r_free_bits;
    logic [TAG_BITS:0]                r_free_count;
    logic                             r_double_free;

    logic [N_PHYS_REG-1:0]            w_mask;
    logic [N_WAY-1:0][TAG_BITS-1:0]   w_free_tag;
    logic [N_WAY-1:0]                 w_free_valid;
    logic [N_PHYS_REG-1:0]            w_alloc_mask;
    logic [N_PHYS_REG-1:0]            w_kept;
    logic [N_PHYS_REG-1:0]            w_free_mask;
    logic [N_PHYS_REG-1:0]            w_next;
    logic                             w_dup;
    logic                             w_hit;

    function automatic logic [TAG_BITS:0] popcount(input logic [N_PHYS_REG-1:0] v);
        logic [TAG_BITS:0] cnt;
        cnt = '0;
        for (int k = 0; k < N_PHYS_REG; k++) begin
            cnt = cnt + {{TAG_BITS{1'b0}}, v[k]};
        end
        return cnt;
    endfunction

    // Pick the N_WAY lowest set bits; each lane removes its pick before the next lane scans.
    always_comb begin
        w_mask       = r_free_bits;
        w_free_tag   = '0;
        w_free_valid = '0;
        for (int i = 0; i < N_WAY; i++) begin
            for (int k = N_PHYS_REG - 1; k >= 0; k--) begin
                w_free_tag[i]   = w_mask[k] ? TAG_BITS'(k) : w_free_tag[i];
                w_free_valid[i] = w_free_valid[i] | w_mask[k];
            end
            w_mask[w_free_tag[i]] = 1'b0;
        end
    end

    // Build allocate/free masks and detect frees of tags that are already (or twice) free.
    always_comb begin
        w_alloc_mask = '0;
        for (int i = 0; i < N_WAY; i++) begin
            w_alloc_mask[w_free_tag[i]] = w_alloc_mask[w_free_tag[i]]
                | (bus.alloc_en[i] & w_free_valid[i] & ~bus.branch_haz);
        end
        w_kept      = r_free_bits & ~w_alloc_mask;
        w_free_mask = '0;
        w_dup       = 1'b0;
        w_hit       = 1'b0;
        for (int i = 0; i < N_WAY; i++) begin
            w_hit = bus.retire_valid[i] & (bus.retire_told[i] != ZERO_TAG);
            w_dup = w_dup | (w_hit & (w_kept[bus.retire_told[i]] | w_free_mask[bus.retire_told[i]]));
            w_free_mask[bus.retire_told[i]] = w_free_mask[bus.retire_told[i]] | w_hit;
        end
        for (int j = 0; j < N_ROB; j++) begin
            w_hit = bus.branch_haz & (bus.free_list_haz[j] != ZERO_TAG);
            w_dup = w_dup | (w_hit & (w_kept[bus.free_list_haz[j]] | w_free_mask[bus.free_list_haz[j]]));
            w_free_mask[bus.free_list_haz[j]] = w_free_mask[bus.free_list_haz[j]] | w_hit;
        end
        w_next = w_kept | w_free_mask;
    end

    // Free-list state; the count is recomputed from the new bitmap so it cannot drift.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_free_bits   <= RESET_BITS;
            r_free_count  <= (TAG_BITS+1)'(N_PHYS_REG - N_ARCH_REG);
            r_double_free <= 1'b0;
        end else begin
            r_free_bits   <= w_next;
            r_free_count  <= popcount(w_next);
            r_double_free <= r_double_free | w_dup;
        end
    end

    assign bus.free_tag    = w_free_tag;
    assign bus.free_valid  = w_free_valid;
    assign bus.free_count  = r_free_count;
    assign bus.double_free = r_double_free;
    assign bus.num_free    = (r_free_count > (TAG_BITS+1)'(N_WAY)) ? NF_BITS'(N_WAY)
                                                                   : NF_BITS'(r_free_count);
endmodule

// File: tb/tb_phys_free_list.sv
// Scoreboard bench for phys_free_list: a behavioural bitmap model predicts the
// post-edge outputs of every driven cycle, which are compared one cycle later.
module tb_phys_free_list;
    localparam int NW = 2;
    localparam int NR = 32;
    localparam int NP = 64;
    localparam int TB = 6;

    typedef struct packed {
        logic [TB-1:0] t0;
        logic [TB-1:0] t1;
        logic [1:0]    v;
        logic [1:0]    nf;
        logic [TB:0]   cnt;
        logic          df;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    exp_t            sb_q[$];
    logic [NP-1:0]   m_free;
    logic            m_df;
    int              n_cmp = 0;
    int              n_err = 0;
    logic [NR-1:0][TB-1:0] haz;

    phys_free_list_if #(.N_WAY(NW), .N_ROB(NR), .TAG_BITS(TB)) bus ();

    phys_free_list #(
        .N_WAY(NW), .N_ROB(NR), .N_PHYS_REG(NP), .N_ARCH_REG(32), .TAG_BITS(TB), .ZERO_REG_PR(0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected visible outputs for a given free bitmap
    function automatic exp_t outputs_of(input logic [NP-1:0] bits, input logic df);
        exp_t e;
        int   list[$];
        for (int k = 0; k < NP; k++) if (bits[k]) list.push_back(k);
        e.t0  = (list.size() > 0) ? TB'(list[0]) : '0;
        e.t1  = (list.size() > 1) ? TB'(list[1]) : '0;
        e.v   = {list.size() > 1, list.size() > 0};
        e.cnt = (TB+1)'(list.size());
        e.nf  = (list.size() >= 2) ? 2'd2 : 2'(list.size());
        e.df  = df;
        return e;
    endfunction

    task automatic compare_pop();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_val("free_tag0",   32'(bus.free_tag[0]), 32'(e.t0));
            check_val("free_tag1",   32'(bus.free_tag[1]), 32'(e.t1));
            check_val("free_valid",  32'(bus.free_valid),  32'(e.v));
            check_val("num_free",    32'(bus.num_free),    32'(e.nf));
            check_val("free_count",  32'(bus.free_count),  32'(e.cnt));
            check_val("double_free", 32'(bus.double_free), 32'(e.df));
        end
    endtask

    // Drive one cycle, predict its effect with the model, and check after the edge
    task automatic step(input logic [1:0] ae, input logic [1:0] rv, input logic [TB-1:0] rt0,
                        input logic [TB-1:0] rt1, input logic bh, input logic [NR-1:0][TB-1:0] hz);
        int            avail[$];
        int            frees[$];
        logic [NP-1:0] after_alloc;
        logic [NP-1:0] seen;
        bus.alloc_en      = ae;
        bus.retire_valid  = rv;
        bus.retire_told   = {rt1, rt0};
        bus.branch_haz    = bh;
        bus.free_list_haz = hz;
        for (int k = 0; k < NP; k++) if (m_free[k]) avail.push_back(k);
        after_alloc = m_free;
        if (!bh) begin
            if (ae[0] && avail.size() > 0) after_alloc[avail[0]] = 1'b0;
            if (ae[1] && avail.size() > 1) after_alloc[avail[1]] = 1'b0;
        end
        if (rv[0] && rt0 != 0) frees.push_back(int'(rt0));
        if (rv[1] && rt1 != 0) frees.push_back(int'(rt1));
        if (bh) for (int j = 0; j < NR; j++) if (hz[j] != 0) frees.push_back(int'(hz[j]));
        seen = '0;
        foreach (frees[f]) begin
            if (after_alloc[frees[f]] || seen[frees[f]]) m_df = 1'b1;
            seen[frees[f]] = 1'b1;
        end
        m_free = after_alloc | seen;
        sb_q.push_back(outputs_of(m_free, m_df));
        @(posedge clock);
        #1;
        compare_pop();
    endtask

    task automatic do_reset(input logic [1:0] ae, input logic [1:0] rv);
        reset            = 1'b1;
        bus.alloc_en     = ae;
        bus.retire_valid = rv;
        bus.retire_told  = {6'd33, 6'd40};
        bus.branch_haz   = 1'b0;
        bus.free_list_haz = '0;
        @(posedge clock);
        #1;
        reset  = 1'b0;
        m_free = {NP{1'b1}} << 32;
        m_df   = 1'b0;
        sb_q.delete();
        check_val("rst_tag0",  32'(bus.free_tag[0]), 32'd32);
        check_val("rst_tag1",  32'(bus.free_tag[1]), 32'd33);
        check_val("rst_valid", 32'(bus.free_valid),  32'd3);
        check_val("rst_num",   32'(bus.num_free),    32'd2);
        check_val("rst_count", 32'(bus.free_count),  32'd32);
        check_val("rst_df",    32'(bus.double_free), 32'd0);
    endtask

    initial begin
        haz = '0;
        do_reset(2'b00, 2'b00);

        // Drain the pool two tags per cycle in ascending order
        for (int c = 0; c < 16; c++) begin
            check_val("drain_tag0", 32'(bus.free_tag[0]), 32'(32 + 2 * c));
            check_val("drain_tag1", 32'(bus.free_tag[1]), 32'(33 + 2 * c));
            step(2'b11, 2'b00, 6'd0, 6'd0, 1'b0, haz);
        end
        check_val("empty_count", 32'(bus.free_count), 32'd0);
        check_val("empty_valid", 32'(bus.free_valid), 32'd0);
        check_val("empty_num",   32'(bus.num_free),   32'd0);
        step(2'b11, 2'b00, 6'd0, 6'd0, 1'b0, haz);

        // Retire into an empty pool while dispatch asks for tags
        step(2'b11, 2'b11, 6'd35, 6'd40, 1'b0, haz);
        check_val("ret_tag0",  32'(bus.free_tag[0]), 32'd35);
        check_val("ret_tag1",  32'(bus.free_tag[1]), 32'd40);
        check_val("ret_count", 32'(bus.free_count),  32'd2);
        step(2'b11, 2'b00, 6'd0, 6'd0, 1'b0, haz);
        step(2'b00, 2'b01, 6'd50, 6'd0, 1'b0, haz);

        // Same-cycle allocate of 50 and free of 12
        step(2'b01, 2'b01, 6'd12, 6'd0, 1'b0, haz);
        check_val("swap_tag0",  32'(bus.free_tag[0]), 32'd12);
        check_val("swap_count", 32'(bus.free_count),  32'd1);

        // Branch flush reclaim plus a retire; allocation squashed
        haz[0] = 6'd45; haz[1] = 6'd46; haz[2] = 6'd47;
        step(2'b11, 2'b01, 6'd44, 6'd0, 1'b1, haz);
        check_val("flush_count", 32'(bus.free_count),  32'd5);
        check_val("flush_tag1",  32'(bus.free_tag[1]), 32'd44);
        haz = '0;

        // Double free of 33, then a retire of the zero register
        step(2'b00, 2'b01, 6'd33, 6'd0, 1'b0, haz);
        check_val("df_clear", 32'(bus.double_free), 32'd0);
        step(2'b00, 2'b01, 6'd33, 6'd0, 1'b0, haz);
        check_val("df_set", 32'(bus.double_free), 32'd1);
        step(2'b00, 2'b10, 6'd0, 6'd0, 1'b0, haz);
        check_val("zero_tag0", 32'(bus.free_tag[0]), 32'd12);
        check_val("df_sticky", 32'(bus.double_free), 32'd1);

        // Reset wins over same-cycle alloc/free; then a duplicate free in one cycle
        do_reset(2'b11, 2'b11);
        step(2'b00, 2'b11, 6'd20, 6'd20, 1'b0, haz);
        check_val("dup_df", 32'(bus.double_free), 32'd1);

        do_reset(2'b00, 2'b00);
        for (int c = 0; c < 150; c++) begin
            logic [1:0] ae;
            logic       bh;
            logic [NR-1:0][TB-1:0] rh;
            ae = ($urandom_range(0, 2) == 0) ? 2'b00 : (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11);
            bh = ($urandom_range(0, 15) == 0);
            rh = '0;
            for (int j = 0; j < NR; j++) if ($urandom_range(0, 7) == 0) rh[j] = TB'($urandom_range(0, NP - 1));
            step(ae, 2'($urandom_range(0, 3)), TB'($urandom_range(0, NP - 1)),
                 TB'($urandom_range(0, NP - 1)), bh, rh);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
